encrypt_sequencer: RTL and testbench

- Control and collection stage wrapped around the combinational subset-sum encrypt datapath.
- Accepts one plaintext per encryption and draws a fresh BIG_N-bit subset mask from an internal LFSR.
- Steps the transposed public-key row index 0..DIMENSION and captures each row's subset sum. Rows 0..DIMENSION-1 are the a-components and row DIMENSION is the b-component, which gets the encoded plaintext added.
- Streams the DIMENSION+1 ciphertext words out over a valid/ready handshake with backpressure.

---
 rtl/encrypt_pkg.sv | 27 ++
 rtl/noise_lfsr.sv | 52 +++++
 rtl/encrypt_sequencer.sv | 158 +++++++++++++++
 tb/tb_encrypt_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/encrypt_pkg.sv
// Shared definitions for the subset-sum encryption stages.
// Holds the sequencer state encoding, the default LWE parameter set and
// the default LFSR feedback polynomial used by the noise generators.
package encrypt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int unsigned DEF_PLAINTEXT_MODULUS  = 64;
  localparam int unsigned DEF_PLAINTEXT_WIDTH    = 6;
  localparam int unsigned DEF_DIMENSION          = 1;
  localparam int unsigned DEF_CIPHERTEXT_MODULUS = 1024;
  localparam int unsigned DEF_CIPHERTEXT_WIDTH   = 10;
  localparam int unsigned DEF_BIG_N              = 30;
  localparam int unsigned DEF_ROW_WIDTH          = 2;

  // Plaintext is scaled by q/p, i.e. shifted left by log2(q) - log2(p).
  localparam int unsigned DEF_ENC_SHIFT = DEF_CIPHERTEXT_WIDTH - DEF_PLAINTEXT_WIDTH;

  // x^30 + x^6 + x^4 + x + 1
  localparam logic [29:0] DEF_LFSR_TAPS = 30'h20000029;
  localparam logic [29:0] DEF_LFSR_SEED = 30'h1;

endpackage

// File: rtl/noise_lfsr.sv
// Fibonacci LFSR that produces a fresh WIDTH-bit word per step.
// Each step applies WIDTH single-bit shifts, so consecutive outputs share
// no bits. A zero seed is replaced by 1 so the register never locks up.
// Ports:
//   clk_i   clock
//   rst_i   synchronous active-high reset, loads the seed
//   step_i  advance by one full word
//   state_o current register contents
module noise_lfsr #(
  parameter int unsigned       WIDTH = 30,
  parameter logic [WIDTH-1:0]  TAPS  = encrypt_pkg::DEF_LFSR_TAPS,
  parameter logic [WIDTH-1:0]  SEED  = encrypt_pkg::DEF_LFSR_SEED
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             step_i,
  output logic [WIDTH-1:0] state_o
);

  localparam logic [WIDTH-1:0] RESET_VAL =
    (SEED == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : SEED;

  function automatic logic [WIDTH-1:0] advance_word(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] v;
    v = s;
    for (int i = 0; i < WIDTH; i++) begin
      v = {v[WIDTH-2:0], ^(v & TAPS)};
    end
    return v;
  endfunction

  logic [WIDTH-1:0] lfsr_q;
  logic [WIDTH-1:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (step_i) begin
      lfsr_d = advance_word(lfsr_q);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/encrypt_sequencer.sv
// Control and collection stage around the combinational subset-sum
// encrypt datapath. On each accepted start it draws a new subset mask,
// walks the public-key rows 0..DIMENSION, captures each row's subset sum
// (adding the encoded plaintext to the last, b, row) and streams the
// DIMENSION+1 ciphertext words over a valid/ready handshake.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start/start_ready new-encryption request; ready only in IDLE
//   plaintext         message, captured on start acceptance
//   noise_select      subset mask to the datapath, fixed per encryption
//   row               public-key row index to the datapath
//   psum_in           subset sum mod q for the current row
//   ct_valid/ct_ready output handshake
//   ct_data/ct_index/ct_last  ciphertext word, its index, last-word flag
module encrypt_sequencer
  import encrypt_pkg::*;
#(
  parameter int unsigned       PLAINTEXT_MODULUS  = DEF_PLAINTEXT_MODULUS,
  parameter int unsigned       PLAINTEXT_WIDTH    = DEF_PLAINTEXT_WIDTH,
  parameter int unsigned       DIMENSION          = DEF_DIMENSION,
  parameter int unsigned       CIPHERTEXT_MODULUS = DEF_CIPHERTEXT_MODULUS,
  parameter int unsigned       CIPHERTEXT_WIDTH   = DEF_CIPHERTEXT_WIDTH,
  parameter int unsigned       BIG_N              = DEF_BIG_N,
  parameter int unsigned       ROW_WIDTH          = DEF_ROW_WIDTH,
  parameter logic [BIG_N-1:0]  LFSR_TAPS          = DEF_LFSR_TAPS,
  parameter logic [BIG_N-1:0]  LFSR_SEED          = DEF_LFSR_SEED
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        start_ready,
  input  logic [PLAINTEXT_WIDTH-1:0]  plaintext,
  output logic [BIG_N-1:0]            noise_select,
  output logic [ROW_WIDTH-1:0]        row,
  input  logic [CIPHERTEXT_WIDTH-1:0] psum_in,
  output logic                        ct_valid,
  input  logic                        ct_ready,
  output logic [CIPHERTEXT_WIDTH-1:0] ct_data,
  output logic [ROW_WIDTH-1:0]        ct_index,
  output logic                        ct_last
);

  localparam int unsigned            ENC_SHIFT = CIPHERTEXT_WIDTH - PLAINTEXT_WIDTH;
  localparam logic [ROW_WIDTH-1:0]   LAST_ROW  = ROW_WIDTH'(DIMENSION);

  // Reject parameter sets the arithmetic below cannot represent.
  if ((PLAINTEXT_MODULUS != (1 << PLAINTEXT_WIDTH)) ||
      (CIPHERTEXT_MODULUS != (1 << CIPHERTEXT_WIDTH)) ||
      (CIPHERTEXT_WIDTH <= PLAINTEXT_WIDTH) ||
      ((1 << ROW_WIDTH) <= DIMENSION)) begin : g_bad_params
    $error("encrypt_sequencer: inconsistent LWE parameters");
  end

  state_e                        state_q, state_d;
  logic [ROW_WIDTH-1:0]          row_q, row_d;
  logic [PLAINTEXT_WIDTH-1:0]    pt_q, pt_d;
  logic                          ct_valid_q, ct_valid_d;
  logic [CIPHERTEXT_WIDTH-1:0]   ct_data_q, ct_data_d;
  logic [ROW_WIDTH-1:0]          ct_index_q, ct_index_d;
  logic                          ct_last_q, ct_last_d;

  logic                          lfsr_step;
  logic                          slot_free;
  logic                          is_last_row;
  logic [CIPHERTEXT_WIDTH-1:0]   enc;

  noise_lfsr #(
    .WIDTH (BIG_N),
    .TAPS  (LFSR_TAPS),
    .SEED  (LFSR_SEED)
  ) u_noise_lfsr (
    .clk_i   (clk),
    .rst_i   (rst),
    .step_i  (lfsr_step),
    .state_o (noise_select)
  );

  assign start_ready = (state_q == ST_IDLE);
  assign lfsr_step   = start & start_ready;
  // The output register can take a new word when empty or draining this cycle.
  assign slot_free   = !ct_valid_q | ct_ready;
  assign is_last_row = (row_q == LAST_ROW);
  assign enc         = CIPHERTEXT_WIDTH'(pt_q) << ENC_SHIFT;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    pt_d       = pt_q;
    ct_valid_d = ct_valid_q;
    ct_data_d  = ct_data_q;
    ct_index_d = ct_index_q;
    ct_last_d  = ct_last_q;

    // A word leaving without replacement empties the register.
    if (ct_valid_q && ct_ready) begin
      ct_valid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          pt_d    = plaintext;
          row_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (slot_free) begin
          // Sum wraps mod q by truncation to CIPHERTEXT_WIDTH.
          ct_data_d  = psum_in + (is_last_row ? enc : '0);
          ct_index_d = row_q;
          ct_last_d  = is_last_row;
          ct_valid_d = 1'b1;
          if (is_last_row) begin
            state_d = ST_DONE;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (ct_valid_q && ct_ready && ct_last_q) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      row_q      <= '0;
      pt_q       <= '0;
      ct_valid_q <= 1'b0;
      ct_data_q  <= '0;
      ct_index_q <= '0;
      ct_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      pt_q       <= pt_d;
      ct_valid_q <= ct_valid_d;
      ct_data_q  <= ct_data_d;
      ct_index_q <= ct_index_d;
      ct_last_q  <= ct_last_d;
    end
  end

  assign row      = row_q;
  assign ct_valid = ct_valid_q;
  assign ct_data  = ct_data_q;
  assign ct_index = ct_index_q;
  assign ct_last  = ct_last_q;

endmodule

// File: tb/tb_encrypt_sequencer.sv
// Directed bench for encrypt_sequencer with default parameters.
// The datapath is modelled as a per-row subset-sum table driven by the bench.
module tb_encrypt_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        start_ready;
  logic [5:0]  plaintext;
  logic [29:0] noise_select;
  logic [1:0]  row;
  logic [9:0]  psum_in;
  logic        ct_valid;
  logic        ct_ready;
  logic [9:0]  ct_data;
  logic [1:0]  ct_index;
  logic        ct_last;

  logic [9:0]  psum_r0;
  logic [9:0]  psum_r1;

  int checks   = 0;
  int failures = 0;

  logic [29:0] ref_lfsr;

  typedef struct {
    logic [5:0] pt;
    logic [9:0] ps0;
    logic [9:0] ps1;
    logic [9:0] exp0;
    logic [9:0] exp1;
  } vec_t;

  vec_t vecs [5];

  always #5 clk = ~clk;

  // Datapath stand-in: subset sum depends on the row being presented.
  always_comb psum_in = (row == 2'd0) ? psum_r0 : psum_r1;

  encrypt_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .start_ready  (start_ready),
    .plaintext    (plaintext),
    .noise_select (noise_select),
    .row          (row),
    .psum_in      (psum_in),
    .ct_valid     (ct_valid),
    .ct_ready     (ct_ready),
    .ct_data      (ct_data),
    .ct_index     (ct_index),
    .ct_last      (ct_last)
  );

  function automatic logic [29:0] lfsr_model(input logic [29:0] s);
    logic [29:0] v;
    logic        fb;
    v = s;
    for (int i = 0; i < 30; i++) begin
      fb = v[29] ^ v[5] ^ v[3] ^ v[0];
      v  = {v[28:0], fb};
    end
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One encryption with ct_ready held high; start accepted at the first edge.
  task automatic run_vec(input vec_t v, input string tag);
    logic [29:0] prev_noise;
    prev_noise = noise_select;
    plaintext  = v.pt;
    psum_r0    = v.ps0;
    psum_r1    = v.ps1;
    ct_ready   = 1'b1;
    start      = 1'b1;
    chk({tag, "_ready_pre"}, start_ready, 1);
    cyc();
    start    = 1'b0;
    ref_lfsr = lfsr_model(ref_lfsr);
    chk({tag, "_noise"}, noise_select, ref_lfsr);
    chk({tag, "_noise_changed"}, (noise_select != prev_noise), 1);
    chk({tag, "_busy"}, start_ready, 0);
    chk({tag, "_no_early_valid"}, ct_valid, 0);
    chk({tag, "_row0"}, row, 0);
    cyc();
    chk({tag, "_w0_valid"}, ct_valid, 1);
    chk({tag, "_w0_data"}, ct_data, v.exp0);
    chk({tag, "_w0_index"}, ct_index, 0);
    chk({tag, "_w0_last"}, ct_last, 0);
    chk({tag, "_row1"}, row, 1);
    cyc();
    chk({tag, "_w1_valid"}, ct_valid, 1);
    chk({tag, "_w1_data"}, ct_data, v.exp1);
    chk({tag, "_w1_index"}, ct_index, 1);
    chk({tag, "_w1_last"}, ct_last, 1);
    chk({tag, "_row_hold"}, row, 1);
    cyc();
    chk({tag, "_end_valid"}, ct_valid, 0);
    chk({tag, "_end_ready"}, start_ready, 1);
    chk({tag, "_data_hold"}, ct_data, v.exp1);
    chk({tag, "_noise_hold"}, noise_select, ref_lfsr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int words;
    vecs[0] = '{pt: 6'd5,  ps0: 10'd100,  ps1: 10'd1000, exp0: 10'd100,  exp1: 10'd56};
    vecs[1] = '{pt: 6'd0,  ps0: 10'd17,   ps1: 10'd300,  exp0: 10'd17,   exp1: 10'd300};
    vecs[2] = '{pt: 6'd63, ps0: 10'd5,    ps1: 10'd1000, exp0: 10'd5,    exp1: 10'd984};
    vecs[3] = '{pt: 6'd1,  ps0: 10'd1023, ps1: 10'd1023, exp0: 10'd1023, exp1: 10'd15};
    vecs[4] = '{pt: 6'd63, ps0: 10'd0,    ps1: 10'd0,    exp0: 10'd0,    exp1: 10'd1008};

    rst = 1'b1; start = 1'b0; plaintext = '0; ct_ready = 1'b1;
    psum_r0 = '0; psum_r1 = '0;
    ref_lfsr = 30'h1;

    // Reset state
    cyc(); cyc();
    rst = 1'b0;
    chk("rst_start_ready", start_ready, 1);
    chk("rst_ct_valid", ct_valid, 0);
    chk("rst_row", row, 0);
    chk("rst_noise", noise_select, 30'h1);
    chk("rst_ct_data", ct_data, 0);
    chk("rst_ct_index", ct_index, 0);
    chk("rst_ct_last", ct_last, 0);
    cyc();
    chk("idle_ready", start_ready, 1);

    // Back-to-back encryptions from the table
    for (int i = 0; i < 5; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Backpressure on word 0
    plaintext = 6'd5; psum_r0 = 10'd100; psum_r1 = 10'd1000;
    ct_ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    ref_lfsr = lfsr_model(ref_lfsr);
    chk("bp_noise", noise_select, ref_lfsr);
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("bp_valid", ct_valid, 1);
      chk("bp_data", ct_data, 100);
      chk("bp_index", ct_index, 0);
      chk("bp_row", row, 1);
      psum_r1 = 10'd1000 - 10'(k);
      cyc();
    end
    psum_r1 = 10'd1000;
    chk("bp_still_w0", ct_index, 0);
    ct_ready = 1'b1;
    cyc();
    chk("bp_w1_valid", ct_valid, 1);
    chk("bp_w1_data", ct_data, 56);
    chk("bp_w1_last", ct_last, 1);
    cyc();
    chk("bp_end_valid", ct_valid, 0);
    chk("bp_end_ready", start_ready, 1);

    // start held through RUN and DONE must not re-trigger
    plaintext = 6'd2; psum_r0 = 10'd7; psum_r1 = 10'd9;
    words = 0;
    start = 1'b1; ct_ready = 1'b1;
    cyc();
    ref_lfsr = lfsr_model(ref_lfsr);
    for (int k = 0; k < 9; k++) begin
      ct_ready = (k == 2) ? 1'b0 : 1'b1;
      start    = (k <= 3) ? 1'b1 : 1'b0;
      if (ct_valid && ct_ready) begin
        words++;
        chk("ign_data", ct_data, (ct_index == 2'd0) ? 32'd7 : 32'd41);
      end
      if (k == 4) chk("ign_ready_back", start_ready, 1);
      chk("ign_noise", noise_select, ref_lfsr);
      cyc();
    end
    chk("ign_word_count", words, 2);

    // Reset while word 0 is stalled
    plaintext = 6'd9; psum_r0 = 10'd200; psum_r1 = 10'd10;
    ct_ready = 1'b0; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("mid_w0_valid", ct_valid, 1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    ref_lfsr = 30'h1;
    chk("mid_valid", ct_valid, 0);
    chk("mid_ready", start_ready, 1);
    chk("mid_noise", noise_select, 30'h1);
    chk("mid_row", row, 0);
    run_vec(vecs[0], "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
